// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/grant types for the IF/DM memory arbiter.
// Optional tie statistics are enabled with MEM_ARB_STATS_EN.
package mem_arbiter_pkg;

  localparam int LATENCY_DEFAULT = 2;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  // Alternate on ties so neither port starves.
  function automatic gnt_e tie_pick(gnt_e last);
    return (last == GNT_DM) ? GNT_IF : GNT_DM;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable down-counter, holds at zero.
// Used by mem_arbiter (MEM_ARB_STATS_EN has no effect here).
module mem_arb_timer
  import mem_arbiter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports.
// Define MEM_ARB_STATS_EN to add the conflict_cnt_o tie counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o
`ifdef MEM_ARB_STATS_EN
 ,output logic [15:0] conflict_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] LOAD_VAL =
    CNT_W'(LATENCY - 1);

  state_e state_q;
  state_e state_d;
  gnt_e   last_q;
  gnt_e   gnt_sel;

  logic        gnt_v;
  logic        done;
  logic        if_elig;
  logic        dm_elig;
  logic        cnt_zero;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  assign if_elig = if_req_i & ~if_ack_o;
  assign dm_elig = dm_req_i & ~dm_ack_o;

  always_comb begin
    state_d = state_q;
    gnt_v   = 1'b0;
    gnt_sel = GNT_IF;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (if_elig && dm_elig): begin
            gnt_v   = 1'b1;
            gnt_sel = tie_pick(last_q);
          end
          (dm_elig && !if_elig): begin
            gnt_v   = 1'b1;
            gnt_sel = GNT_DM;
          end
          (if_elig && !dm_elig): begin
            gnt_v   = 1'b1;
            gnt_sel = GNT_IF;
          end
          default: ;
        endcase
        if (gnt_v) begin
          state_d = (gnt_sel == GNT_DM) ?
                    BUSY_DM : BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (cnt_zero) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      last_q     <= GNT_IF;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      if_ack_o   <= 1'b0;
      dm_ack_o   <= 1'b0;
      if_rdata_o <= '0;
      dm_rdata_o <= '0;
    end else begin
      state_q  <= state_d;
      if_ack_o <= done && (state_q == BUSY_IF);
      dm_ack_o <= done && (state_q == BUSY_DM);
      if (gnt_v) begin
        last_q <= gnt_sel;
        if (gnt_sel == GNT_DM) begin
          lat_we    <= dm_we_i;
          lat_addr  <= dm_addr_i;
          lat_wdata <= dm_wdata_i;
        end else begin
          lat_we    <= 1'b0;
          lat_addr  <= if_addr_i;
          lat_wdata <= '0;
        end
      end
      if (done && (state_q == BUSY_IF)) begin
        if_rdata_o <= mem_rdata_i;
      end
      if (done && (state_q == BUSY_DM)) begin
        dm_rdata_o <= mem_rdata_i;
      end
    end
  end

  mem_arb_timer u_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (gnt_v),
    .load_val_i (LOAD_VAL),
    .dec_i      (state_q != IDLE),
    .zero_o     (cnt_zero)
  );

  assign mem_en_o    = (state_q != IDLE);
  assign mem_we_o    = (state_q == BUSY_DM) & lat_we;
  assign mem_addr_o  = lat_addr;
  assign mem_wdata_o = lat_wdata;

  assign stall_o = (if_req_i & ~if_ack_o) |
                   (dm_req_i & ~dm_ack_o);

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      conflict_cnt_o <= '0;
    end else if ((state_q == IDLE) && if_elig &&
                 dm_elig && (conflict_cnt_o != 16'hFFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter at LATENCY=2.
// Checks conflict_cnt_o too when built with MEM_ARB_STATS_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        stall;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] ccnt;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(2)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_rdata_o  (if_rdata),
    .if_ack_o    (if_ack),
    .dm_req_i    (dm_req),
    .dm_we_i     (dm_we),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_rdata_o  (dm_rdata),
    .dm_ack_o    (dm_ack),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .stall_o     (stall)
`ifdef MEM_ARB_STATS_EN
   ,.conflict_cnt_o (ccnt)
`endif
  );

  // Preloaded words; stores override via wvld.
  function automatic logic [31:0] rom(input logic [5:0] i);
    case (i)
      6'd1:    return 32'h8C01_0000;
      6'd2:    return 32'h3333_4444;
      6'd3:    return 32'h5555_6666;
      6'd4:    return 32'h1111_2222;
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] mem [0:63];
  bit   [63:0] wvld;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[7:2]]  <= mem_wdata;
      wvld[mem_addr[7:2]] <= 1'b1;
    end
    if (mem_en) begin
      mem_rdata <= wvld[mem_addr[7:2]] ?
                   mem[mem_addr[7:2]] :
                   rom(mem_addr[7:2]);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    repeat (2) nx();
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_acks", 32'({if_ack, dm_ack}), 32'd0);
    chk("rst_ifrd", if_rdata, 32'h0);
    chk("rst_dmrd", dm_rdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
`ifdef MEM_ARB_STATS_EN
    chk("rst_ccnt", 32'(ccnt), 32'd0);
`endif
    rst_n = 1'b1;

    // IF-only fetch
    if_req  = 1'b1;
    if_addr = 32'h4;
    #1;
    chk("f_stall", 32'(stall), 32'd1);
    nx();
    chk("f_en1", 32'(mem_en), 32'd1);
    chk("f_addr", mem_addr, 32'h4);
    chk("f_we", 32'(mem_we), 32'd0);
    chk("f_ack1", 32'(if_ack), 32'd0);
    nx();
    chk("f_en2", 32'(mem_en), 32'd1);
    nx();
    chk("f_ack", 32'(if_ack), 32'd1);
    chk("f_rdata", if_rdata, 32'h8C01_0000);
    chk("f_en3", 32'(mem_en), 32'd0);
    chk("f_stall_ack", 32'(stall), 32'd0);
    if_req = 1'b0;
    nx();
    chk("f_ack_off", 32'(if_ack), 32'd0);
    chk("f_hold", if_rdata, 32'h8C01_0000);

    // simultaneous requests: DM first
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h10;
    if_req  = 1'b1;
    if_addr = 32'h8;
    nx();
    chk("t_addr_dm", mem_addr, 32'h10);
    chk("t_we", 32'(mem_we), 32'd0);
    nx();
    nx();
    chk("t_dmack", 32'({dm_ack, if_ack}), 32'b10);
    chk("t_dmrd", dm_rdata, 32'h1111_2222);
    dm_req = 1'b0;
    nx();
    chk("t_addr_if", mem_addr, 32'h8);
    chk("t_dmack_off", 32'(dm_ack), 32'd0);
    nx();
    nx();
    chk("t_ifack", 32'({dm_ack, if_ack}), 32'b01);
    chk("t_ifrd", if_rdata, 32'h3333_4444);
`ifdef MEM_ARB_STATS_EN
    chk("t_ccnt", 32'(ccnt), 32'd1);
`endif
    if_req = 1'b0;
    nx();

    // store then load back
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h20;
    dm_wdata = 32'hDEAD_BEEF;
    nx();
    chk("s_we1", 32'(mem_we), 32'd1);
    chk("s_addr", mem_addr, 32'h20);
    chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    nx();
    chk("s_we2", 32'(mem_we), 32'd1);
    nx();
    chk("s_ack", 32'(dm_ack), 32'd1);
    chk("s_en_ack", 32'(mem_en), 32'd0);
    dm_we = 1'b0;
    nx();
    chk("l_gap", 32'({dm_ack, mem_en}), 32'd0);
    nx();
    chk("l_we", 32'({mem_en, mem_we}), 32'b10);
    chk("l_addr", mem_addr, 32'h20);
    nx();
    nx();
    chk("l_ack", 32'(dm_ack), 32'd1);
    chk("l_rdata", dm_rdata, 32'hDEAD_BEEF);
    dm_req = 1'b0;
    nx();

    // address change after grant is ignored
    if_req  = 1'b1;
    if_addr = 32'hC;
    nx();
    chk("a_addr1", mem_addr, 32'hC);
    if_addr = 32'h40;
    nx();
    chk("a_addr2", mem_addr, 32'hC);
    nx();
    chk("a_ack", 32'(if_ack), 32'd1);
    chk("a_rdata", if_rdata, 32'h5555_6666);
    if_req  = 1'b0;
    if_addr = '0;
    nx();

    // both held: grants alternate DM, IF, ...
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h10;
    if_req  = 1'b1;
    if_addr = 32'h8;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) nx();
      chk($sformatf("alt%0d", i),
          32'({dm_ack, if_ack}),
          32'({(i % 6) == 3, ((i % 6) == 0) && (i > 0)}));
    end
    nx();
    dm_req = 1'b0;
    if_req = 1'b0;
    chk("drop_busy", 32'(dm_ack), 32'd0);
    nx();
    chk("drop_ack", 32'(dm_ack), 32'd1);
    nx();
    chk("drop_idle", 32'({dm_ack, if_ack, mem_en, stall}), 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("alt_ccnt", 32'(ccnt), 32'd2);
`endif

    // reset during first BUSY_DM cycle
    dm_req  = 1'b1;
    dm_addr = 32'h10;
    nx();
    chk("r_en", 32'(mem_en), 32'd1);
    rst_n = 1'b0;
    nx();
    chk("r_en0", 32'(mem_en), 32'd0);
    chk("r_ack0", 32'({dm_ack, if_ack}), 32'd0);
    chk("r_dmrd0", dm_rdata, 32'h0);
    chk("r_ifrd0", if_rdata, 32'h0);
    chk("r_addr0", mem_addr, 32'h0);
`ifdef MEM_ARB_STATS_EN
    chk("r_ccnt0", 32'(ccnt), 32'd0);
`endif
    rst_n   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h8;
    nx();
    chk("r_addr_dm", mem_addr, 32'h10);
    chk("r_noack", 32'(dm_ack), 32'd0);
    nx();
    nx();
    chk("r_dmack", 32'({dm_ack, if_ack}), 32'b10);
    chk("r_dmrd", dm_rdata, 32'h1111_2222);
`ifdef MEM_ARB_STATS_EN
    chk("r_ccnt", 32'(ccnt), 32'd1);
`endif
    dm_req = 1'b0;
    nx();
    nx();
    nx();
    chk("r_ifack", 32'({dm_ack, if_ack}), 32'b01);
    chk("r_ifrd", if_rdata, 32'h3333_4444);
    if_req = 1'b0;
    nx();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
